// File: rtl/sensor_pkg.sv
// Shared constants and types for the track-sensor front end.
// Lockout-related items are only used when SENSOR_LOCKOUT_EN is defined.
package sensor_pkg;

  localparam int SENSOR_NUM_DEF = 3;
  localparam int DEBOUNCE_DEF   = 4;
  localparam int LOCKOUT_DEF    = 16;

  typedef enum logic {LK_IDLE, LK_ACTIVE} lk_state_t;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw sensor inputs and conditioned outputs for both bots, as one bundle.
// The master side drives the raw lines; the slave side is the conditioner.
interface sensor_conditioner_if #(
  parameter int NUM_SENSORS = sensor_pkg::SENSOR_NUM_DEF
);

  logic [NUM_SENSORS-1:0] bot1_sensors_raw;
  logic [NUM_SENSORS-1:0] bot2_sensors_raw;
  logic                   Sensors_reg1;
  logic                   Sensors_reg2;
  logic [NUM_SENSORS-1:0] bot1_stable;
  logic [NUM_SENSORS-1:0] bot2_stable;

  modport master (
    output bot1_sensors_raw, bot2_sensors_raw,
    input  Sensors_reg1, Sensors_reg2, bot1_stable, bot2_stable
  );

  modport slave (
    input  bot1_sensors_raw, bot2_sensors_raw,
    output Sensors_reg1, Sensors_reg2, bot1_stable, bot2_stable
  );

endinterface

// File: rtl/sensor_debounce.sv
// One sensor channel: 2-flop synchronizer, debounce counter and stable bit.
// rise_commit is combinational and marks the edge at which a 0->1 commit happens.
module sensor_debounce
  import sensor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic stable,
  output logic rise_commit
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          commit;

  assign commit      = (s2 != stable) && (cnt == CNT_LAST);
  assign rise_commit = commit && s2;

  // Any cycle where s2 agrees with stable restarts the count, so only an
  // unbroken run of DEBOUNCE_CYCLES disagreeing samples gets committed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (commit) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions both bots' raw sensors into debounced state and one-cycle hit strobes.
// Define SENSOR_LOCKOUT_EN to add the per-bot post-hit lockout window.
module sensor_conditioner
  import sensor_pkg::*;
#(
  parameter int NUM_SENSORS     = SENSOR_NUM_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int LOCKOUT_CYCLES  = LOCKOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  sensor_conditioner_if.slave  sif
);

  logic [NUM_SENSORS-1:0] stable1, stable2;
  logic [NUM_SENSORS-1:0] rise1, rise2;
  logic [1:0]             cand;
  logic [1:0]             hit_q;

  for (genvar i = 0; i < NUM_SENSORS; i++) begin : g_chan
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bot1 (
      .clk         (clk),
      .rst         (rst),
      .raw         (sif.bot1_sensors_raw[i]),
      .stable      (stable1[i]),
      .rise_commit (rise1[i])
    );
    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_bot2 (
      .clk         (clk),
      .rst         (rst),
      .raw         (sif.bot2_sensors_raw[i]),
      .stable      (stable2[i]),
      .rise_commit (rise2[i])
    );
  end

  // Simultaneous rising commits within one bot collapse into a single hit.
  assign cand = {|rise2, |rise1};

`ifdef SENSOR_LOCKOUT_EN
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LK_LOAD = LW'(LOCKOUT_CYCLES);

  for (genvar b = 0; b < 2; b++) begin : g_lockout
    lk_state_t       lk_state;
    logic [LW-1:0]   lk_cnt;

    // Hits arriving while ACTIVE, including on the edge that returns to
    // IDLE, are dropped rather than deferred.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        lk_state <= LK_IDLE;
        lk_cnt   <= '0;
        hit_q[b] <= 1'b0;
      end else begin
        case (lk_state)
          LK_IDLE: begin
            hit_q[b] <= cand[b];
            if (cand[b]) begin
              lk_cnt   <= LK_LOAD;
              lk_state <= LK_ACTIVE;
            end
          end
          LK_ACTIVE: begin
            hit_q[b] <= 1'b0;
            if (lk_cnt == LW'(1)) begin
              lk_cnt   <= '0;
              lk_state <= LK_IDLE;
            end else begin
              lk_cnt <= lk_cnt - 1'b1;
            end
          end
          default: begin
            hit_q[b] <= 1'b0;
            lk_cnt   <= '0;
            lk_state <= LK_IDLE;
          end
        endcase
      end
    end
  end
`else
  // Without lockout the window length has no effect; every hit strobes.
  if (LOCKOUT_CYCLES >= 0) begin : g_direct
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        hit_q <= 2'b00;
      end else begin
        hit_q <= cand;
      end
    end
  end
`endif

  assign sif.Sensors_reg1 = hit_q[0];
  assign sif.Sensors_reg2 = hit_q[1];
  assign sif.bot1_stable  = stable1;
  assign sif.bot2_stable  = stable2;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Self-checking bench for sensor_conditioner: directed scenarios plus random
// stimulus against a timeline-level reference model (honours SENSOR_LOCKOUT_EN).
module tb_sensor_conditioner;

  localparam int NS = 3;
  localparam int D  = 4;
  localparam int L  = 16;

  logic clk;
  logic rst;

  sensor_conditioner_if #(.NUM_SENSORS(NS)) sif ();

  sensor_conditioner #(
    .NUM_SENSORS     (NS),
    .DEBOUNCE_CYCLES (D),
    .LOCKOUT_CYCLES  (L)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int bad;

  // Reference model state: synchronizer pipeline, last D synchronized samples
  // per channel, committed state, and the time of each bot's last strobe.
  logic [2*NS-1:0] m_s1, m_s2, m_stable;
  logic [D-1:0]    m_win [2*NS];
  logic [1:0]      m_hit;
  int              lastStrobe [2];
  bit              haveLast [2];
  int              edgeNo;

  int idx, n1, n2, first1, first2;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", tag, actual, expected, edgeNo);
    end
  endtask

  task automatic modelStep();
    logic [2*NS-1:0] raw;
    logic [2*NS-1:0] rise;
    logic            cand;
    logic            accept;
    raw  = {sif.bot2_sensors_raw, sif.bot1_sensors_raw};
    rise = '0;
    if (rst) begin
      m_s1     = '0;
      m_s2     = '0;
      m_stable = '0;
      for (int i = 0; i < 2*NS; i++) m_win[i] = '0;
      m_hit = 2'b00;
      for (int b = 0; b < 2; b++) haveLast[b] = 1'b0;
    end else begin
      for (int i = 0; i < 2*NS; i++) begin
        m_win[i] = {m_win[i][D-2:0], m_s2[i]};
        if (m_win[i] == {D{~m_stable[i]}}) begin
          rise[i]     = ~m_stable[i];
          m_stable[i] = ~m_stable[i];
        end
      end
      m_s2 = m_s1;
      m_s1 = raw;
      for (int b = 0; b < 2; b++) begin
        cand = |rise[b*NS +: NS];
`ifdef SENSOR_LOCKOUT_EN
        accept = cand && (!haveLast[b] || (edgeNo - lastStrobe[b] > L));
`else
        accept = cand;
`endif
        m_hit[b] = accept;
        if (accept) begin
          lastStrobe[b] = edgeNo;
          haveLast[b]   = 1'b1;
        end
      end
    end
  endtask

  // One clock: update the model at the rising edge, compare at the falling edge.
  task automatic tick();
    @(posedge clk);
    modelStep();
    edgeNo++;
    @(negedge clk);
    checkOutput("reg1", sif.Sensors_reg1, m_hit[0]);
    checkOutput("reg2", sif.Sensors_reg2, m_hit[1]);
    checkOutput("stable1", sif.bot1_stable, m_stable[NS-1:0]);
    checkOutput("stable2", sif.bot2_stable, m_stable[2*NS-1:NS]);
    if (sif.Sensors_reg1) begin
      n1++;
      if (first1 < 0) first1 = idx;
    end
    if (sif.Sensors_reg2) begin
      n2++;
      if (first2 < 0) first2 = idx;
    end
    idx++;
  endtask

  task automatic clearCounts();
    idx = 0; n1 = 0; n2 = 0; first1 = -1; first2 = -1;
  endtask

  task automatic applyStimulus(input logic [NS-1:0] b1, input logic [NS-1:0] b2,
                               input int n);
    sif.bot1_sensors_raw = b1;
    sif.bot2_sensors_raw = b2;
    for (int i = 0; i < n; i++) tick();
  endtask

  int holdCnt [2*NS];
  logic [2*NS-1:0] rvec;

  initial begin
    total = 0;
    bad   = 0;
    edgeNo = 0;
    rst = 1'b1;
    sif.bot1_sensors_raw = '0;
    sif.bot2_sensors_raw = '0;
    clearCounts();

    // Reset held with random raw inputs: everything stays zero.
    for (int i = 0; i < 6; i++)
      applyStimulus(NS'($urandom), NS'($urandom), 1);
    checkOutput("rst_reg1", sif.Sensors_reg1, 0);
    checkOutput("rst_reg2", sif.Sensors_reg2, 0);
    checkOutput("rst_stable1", sif.bot1_stable, 0);
    checkOutput("rst_stable2", sif.bot2_stable, 0);
    sif.bot1_sensors_raw = '0;
    sif.bot2_sensors_raw = '0;
    rst = 1'b0;
    applyStimulus('0, '0, 10);

    // Clean hit on bot 1 bit 0.
    clearCounts();
    applyStimulus(3'b001, 3'b000, 12);
    checkOutput("clean_first", first1, 5);
    checkOutput("clean_n1", n1, 1);
    checkOutput("clean_n2", n2, 0);
    checkOutput("clean_stable", sif.bot1_stable, 3'b001);
    applyStimulus('0, '0, 30);

    // Short glitch: 3 cycles high.
    clearCounts();
    applyStimulus(3'b010, 3'b000, 3);
    applyStimulus(3'b000, 3'b000, 12);
    checkOutput("glitch3_n1", n1, 0);
    checkOutput("glitch3_stable", sif.bot1_stable, 0);

    // Longer pulse: 6 cycles high yields exactly one strobe.
    clearCounts();
    applyStimulus(3'b010, 3'b000, 6);
    applyStimulus(3'b000, 3'b000, 20);
    checkOutput("pulse6_n1", n1, 1);
    checkOutput("pulse6_first", first1, 5);
    applyStimulus('0, '0, 20);

    // Both bots, all sensors at once.
    clearCounts();
    applyStimulus(3'b111, 3'b111, 12);
    checkOutput("simul_n1", n1, 1);
    checkOutput("simul_n2", n2, 1);
    checkOutput("simul_first1", first1, 5);
    checkOutput("simul_same", first2, first1);
    applyStimulus('0, '0, 30);

    // One-cycle reset mid-debounce; held input then rises afresh.
    clearCounts();
    applyStimulus(3'b001, 3'b000, 3);
    rst = 1'b1;
    applyStimulus(3'b001, 3'b000, 1);
    checkOutput("midrst_stable", sif.bot1_stable, 0);
    checkOutput("midrst_reg1", sif.Sensors_reg1, 0);
    rst = 1'b0;
    applyStimulus(3'b001, 3'b000, 12);
    checkOutput("midrst_first", first1, 9);
    checkOutput("midrst_n1", n1, 1);
    applyStimulus('0, '0, 30);

    // Hits at edges 5, 13 and 25: the middle one falls inside the lockout window.
    clearCounts();
    applyStimulus(3'b001, 3'b000, 8);
    applyStimulus(3'b011, 3'b000, 12);
    applyStimulus(3'b111, 3'b000, 12);
    checkOutput("lock_first", first1, 5);
`ifdef SENSOR_LOCKOUT_EN
    checkOutput("lock_n1", n1, 2);
`else
    checkOutput("lock_n1", n1, 3);
`endif
    applyStimulus('0, '0, 30);

    // Random hold times mix glitches with real commits; occasional short resets.
    for (int i = 0; i < 2*NS; i++) holdCnt[i] = $urandom_range(1, 9);
    rvec = '0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 2*NS; i++) begin
        holdCnt[i]--;
        if (holdCnt[i] == 0) begin
          rvec[i]    = ~rvec[i];
          holdCnt[i] = $urandom_range(1, 9);
        end
      end
      rst = ($urandom_range(0, 149) == 0);
      applyStimulus(rvec[NS-1:0], rvec[2*NS-1:NS], 1);
    end
    rst = 1'b0;
    applyStimulus('0, '0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
